instr_mem_responder: RTL and testbench

// - Instruction-memory responder: the slave end of the fetch interface driven by the program counter.
// - Accepts word-address fetch requests through a valid/ready handshake and returns instruction words in order.
// - Read path is registered with fixed latency and backed by a small response buffer, so the fetch side can stall.
// - A preload port writes the program image; bad fetch addresses return a NOP flagged as an error.
//

---
 rtl/mips_fetch_pkg.sv | 14 +
 rtl/resp_fifo.sv | 55 +++++
 rtl/instr_mem_responder.sv | 124 ++++++++++++
 tb/tb_instr_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slave path.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic               err;
        logic [INSTR_W-1:0] instr;
    } fetch_rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO that buffers fetch responses until the fetch side consumes them.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr];

    // NOTE: storage is deliberately left out of reset; the count marks which entries
    // are live, and a resettable array would cost a flop reset per bit for nothing.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory fetch slave: preloadable word memory, fixed-latency read pipe,
// and a credit-guarded response buffer so the fetch side may stall.
module instr_mem_responder
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_err,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = ADDR_W - 2;

    logic [INSTR_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0]  req_word;
    logic [WORD_W-1:0]  load_word;
    logic               load_in_range;
    logic               load_unused;
    logic               accept;
    logic               pop;
    logic               empty;
    logic [CNT_W-1:0]   outstanding;
    fetch_rsp_t         fetch_rsp;
    fetch_rsp_t         push_data;
    fetch_rsp_t         head;
    logic               push_valid;

    assign req_word      = req_addr[ADDR_W-1:2];
    assign load_word     = load_addr[ADDR_W-1:2];
    assign load_in_range = (load_word < WORD_W'(DEPTH_WORDS));
    assign load_unused   = ^load_addr[1:0];

    assign req_ready = (outstanding < CNT_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // A write landing on the same edge as a fetch is not yet visible to that fetch.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) mem[load_word[IDX_W-1:0]] <= load_data;
    end

    // NOTE: defaults are assigned first so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        fetch_rsp.err   = 1'b0;
        fetch_rsp.instr = NOP_INSTR;
        if ((req_addr[1:0] != 2'b00) || (req_word >= WORD_W'(DEPTH_WORDS))) begin
            fetch_rsp.err = 1'b1;
        end else begin
            fetch_rsp.instr = mem[req_word[IDX_W-1:0]];
        end
    end

    // The buffer write itself is the final latency stage; extra stages sit in front of it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept;
            assign push_data  = fetch_rsp;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_valid;
            fetch_rsp_t         pipe_data [LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) pipe_valid[i] <= pipe_valid[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pipe_data[0] <= fetch_rsp;
                for (int i = 1; i < LATENCY - 1; i++) pipe_data[i] <= pipe_data[i-1];
            end

            assign push_valid = pipe_valid[LATENCY-2];
            assign push_data  = pipe_data[LATENCY-2];
        end
    endgenerate

    // Counts pipe plus buffer occupancy, so a push can never find the buffer full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (pop && !accept) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_rsp_t))
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .empty     (empty)
    );

    assign rsp_valid = !empty;
    assign rsp_instr = empty ? NOP_INSTR : head.instr;
    assign rsp_err   = !empty && head.err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: directed vector table, hand-written stall/collision/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_instr_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 1;
    localparam int FIFO_DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH_WORDS];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          due;
    } exp_t;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        if (a[31:2] < DEPTH_WORDS) model_mem[a[9:2]] = d;
        next_cycle();
        load_en = 1'b0;
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a, input int due);
        exp_t e;
        e.err   = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_WORDS);
        e.instr = e.err ? 32'h0 : model_mem[a[9:2]];
        e.due   = due;
        return e;
    endfunction

    function automatic logic [31:0] rand_fetch_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 8) return 32'($urandom_range(0, DEPTH_WORDS - 1)) * 4;
        if (sel == 8) return 32'($urandom_range(0, DEPTH_WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
        return $urandom | 32'h0000_0400;
    endfunction

    vec_t vecs[$];
    exp_t q[$];

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset state while held in reset
        #12;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        check("reset_rsp_instr", rsp_instr,      32'd0);
        #10 rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        next_cycle();

        // Program image: words 0..3 fixed, word 255 fixed, the rest random.
        // Word 3 goes through an address with nonzero low bits, which must be ignored.
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            logic [31:0] d;
            if (i < 4)                  d = 32'h11 * 32'(i + 1);
            else if (i == DEPTH_WORDS - 1) d = 32'hDEAD_BEEF;
            else                        d = $urandom;
            preload(32'(i) * 4 + ((i == 3) ? 32'd3 : 32'd0), d);
        end
        // Out-of-range write must not alias onto word 0
        preload(32'h0000_0400, 32'h5555_5555);

        vecs.push_back('{32'h0000_0000, 32'h0000_0011, 1'b0});
        vecs.push_back('{32'h0000_0004, 32'h0000_0022, 1'b0});
        vecs.push_back('{32'h0000_0008, 32'h0000_0033, 1'b0});
        vecs.push_back('{32'h0000_000C, 32'h0000_0044, 1'b0});
        vecs.push_back('{32'h0000_03FC, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{32'h0000_0006, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_03FD, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h0000_0400, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFFC, 32'h0000_0000, 1'b1});

        foreach (vecs[i]) begin
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            rsp_ready = 1'b1;
            @(negedge clk);
            check($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'd1);
            next_cycle();
            req_valid = 1'b0;
            repeat (LATENCY - 1) next_cycle();
            @(negedge clk);
            check($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("tbl%0d_rsp_instr", i), rsp_instr, vecs[i].instr);
            check($sformatf("tbl%0d_rsp_err", i),   32'(rsp_err), 32'(vecs[i].err));
            next_cycle();
            @(negedge clk);
            check($sformatf("tbl%0d_popped", i), 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Back-to-back fetches, one response per cycle
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_addr = 32'h4;
        @(negedge clk);
        check("b2b_ready1", 32'(req_ready), 32'd1);
        check("b2b_rsp0_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp0", rsp_instr, 32'h11);
        next_cycle();
        req_addr = 32'h8;
        @(negedge clk);
        check("b2b_ready2", 32'(req_ready), 32'd1);
        check("b2b_rsp1", rsp_instr, 32'h22);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp2", rsp_instr, 32'h33);
        check("b2b_rsp2_err", 32'(rsp_err), 32'd0);
        next_cycle();
        @(negedge clk);
        check("b2b_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Stalled fetch side: two accepted, third blocked until the first pop
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_addr = 32'h4;
        next_cycle();
        req_addr = 32'h8;
        @(negedge clk);
        check("stall_ready_full", 32'(req_ready), 32'd0);
        check("stall_head", rsp_instr, 32'h11);
        next_cycle();
        @(negedge clk);
        check("stall_still_full", 32'(req_ready), 32'd0);
        check("stall_head_stable", rsp_instr, 32'h11);
        check("stall_valid_stable", 32'(rsp_valid), 32'd1);
        next_cycle();
        rsp_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("stall_ready_after_pop", 32'(req_ready), 32'd1);
        check("stall_second", rsp_instr, 32'h22);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_third", rsp_instr, 32'h33);
        check("stall_third_valid", 32'(rsp_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("stall_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Load and fetch of the same word on the same edge
        load_en   = 1'b1;
        load_addr = 32'h8;
        load_data = 32'hAA;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        next_cycle();
        load_en      = 1'b0;
        req_valid    = 1'b0;
        model_mem[2] = 32'hAA;
        @(negedge clk);
        check("collide_old_data", rsp_instr, 32'h33);
        next_cycle();
        req_valid = 1'b1;
        req_addr  = 32'h8;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("collide_new_data", rsp_instr, 32'hAA);
        next_cycle();

        // Reset with two responses outstanding
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_addr = 32'hC;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_pre_valid", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_instr", rsp_instr, 32'd0);
        check("rstmid_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstmid_ready%0d", i), 32'(req_ready), 32'd1);
            check($sformatf("rstmid_no_stale%0d", i), 32'(rsp_valid), 32'd0);
            next_cycle();
        end
        req_valid = 1'b1;
        req_addr  = 32'h4;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_mem_kept_valid", 32'(rsp_valid), 32'd1);
        check("rstmid_mem_kept", rsp_instr, 32'h22);
        next_cycle();

        // Randomized traffic against the reference model
        begin
            int now = 0;
            for (int c = 0; c < 3000; c++) begin
                logic exp_ready;
                logic exp_valid;
                req_valid = ($urandom_range(0, 3) != 0);
                req_addr  = rand_fetch_addr();
                load_en   = ($urandom_range(0, 7) == 0);
                load_addr = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h8000_0000)
                                                         : 32'($urandom_range(0, 4 * DEPTH_WORDS - 1));
                load_data = $urandom;
                rsp_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                exp_ready = (q.size() < FIFO_DEPTH);
                exp_valid = (q.size() > 0) && (q[0].due <= now);
                check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
                check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                if (exp_valid) begin
                    check("rnd_rsp_instr", rsp_instr, q[0].instr);
                    check("rnd_rsp_err", 32'(rsp_err), 32'(q[0].err));
                end
                if (exp_valid && rsp_ready) void'(q.pop_front());
                if (req_valid && exp_ready) q.push_back(model_fetch(req_addr, now + LATENCY));
                if (load_en && (load_addr[31:2] < DEPTH_WORDS)) model_mem[load_addr[9:2]] = load_data;
                next_cycle();
                now++;
            end
        end
        req_valid = 1'b0;
        load_en   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
